// File: rtl/lsu_mem_arbiter_pkg.sv
// lsu_arb_pkg: shared FSM state type and requester-id width helper for lsu_mem_arbiter
package lsu_arb_pkg;

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} arb_state_t;

    // A single requester still needs a 1-bit id so the ports stay legal
    function automatic int req_id_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lsu_mem_arbiter_if.sv
// lsu_mem_arbiter_if: per-thread LSU request side plus the single data-memory channel
//   slave  : arbiter view (takes LSU requests, drives the memory channel)
//   master : environment view (LSUs and memory controller)
interface lsu_mem_arbiter_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int NUM_REQ   = 2
);
    logic [NUM_REQ-1:0]                req_read_valid;
    logic [NUM_REQ-1:0][ADDR_BITS-1:0] req_read_address;
    logic [NUM_REQ-1:0]                req_read_ready;
    logic [NUM_REQ-1:0][DATA_BITS-1:0] req_read_data;
    logic [NUM_REQ-1:0]                req_write_valid;
    logic [NUM_REQ-1:0][ADDR_BITS-1:0] req_write_address;
    logic [NUM_REQ-1:0][DATA_BITS-1:0] req_write_data;
    logic [NUM_REQ-1:0]                req_write_ready;
    logic                              mem_read_valid;
    logic [ADDR_BITS-1:0]              mem_read_address;
    logic                              mem_read_ready;
    logic [DATA_BITS-1:0]              mem_read_data;
    logic                              mem_write_valid;
    logic [ADDR_BITS-1:0]              mem_write_address;
    logic [DATA_BITS-1:0]              mem_write_data;
    logic                              mem_write_ready;

    modport slave (
        input  req_read_valid, req_read_address, req_write_valid, req_write_address, req_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready,
        output req_read_ready, req_read_data, req_write_ready,
        output mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data
    );

    modport master (
        output req_read_valid, req_read_address, req_write_valid, req_write_address, req_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready,
        input  req_read_ready, req_read_data, req_write_ready,
        input  mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data
    );
endinterface

// File: rtl/lsu_mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr (wrapping)
//   req   : request vector
//   ptr   : starting index
//   found : any request set
//   id    : chosen index
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int ID_BITS = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_BITS-1:0] ptr,
    output logic               found,
    output logic [ID_BITS-1:0] id
);
    logic [2*NUM_REQ-1:0] rot;

    // Rotating a doubled copy puts the requester at ptr in bit 0
    assign rot = {req, req} >> ptr;

    always_comb begin
        found = |req;
        id = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--)
            if (rot[j]) id = ID_BITS'((int'(ptr) + j) % NUM_REQ);
    end
endmodule

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: shares one data-memory read/write channel among NUM_REQ LSUs, round-robin
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   bus      : LSU request side and memory channel (lsu_mem_arbiter_if.slave)
//   busy     : high whenever the FSM is not IDLE
//   grant_id : requester currently being served
// Option LSU_ARB_READ_MERGE_EN: same-address reads pending at grant share one memory read.
module lsu_mem_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int DATA_BITS   = 8,
    parameter int NUM_REQ     = 2,
    parameter int REQ_ID_BITS = req_id_bits(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    lsu_mem_arbiter_if.slave       bus,
    output logic                   busy,
    output logic [REQ_ID_BITS-1:0] grant_id
);
    arb_state_t                        state, state_n;
    logic [REQ_ID_BITS-1:0]            id_q, id_n, rr_ptr, rr_ptr_n, pick_id;
    logic                              is_wr, is_wr_n, found;
    logic [ADDR_BITS-1:0]              addr_q, addr_n;
    logic [DATA_BITS-1:0]              wdata_q, wdata_n;
    logic [NUM_REQ-1:0]                mask, pending, req_any;
    logic [NUM_REQ-1:0][DATA_BITS-1:0] rdata;

    assign req_any = bus.req_read_valid | bus.req_write_valid;

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_BITS(REQ_ID_BITS)) u_pick (
        .req(req_any), .ptr(rr_ptr), .found(found), .id(pick_id)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            id_q    <= '0;
            rr_ptr  <= '0;
            is_wr   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state   <= state_n;
            id_q    <= id_n;
            rr_ptr  <= rr_ptr_n;
            is_wr   <= is_wr_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
        end
    end

    always_comb begin
        state_n  = state;
        id_n     = id_q;
        rr_ptr_n = rr_ptr;
        is_wr_n  = is_wr;
        addr_n   = addr_q;
        wdata_n  = wdata_q;
        // Served requesters that still hold valid keep the FSM in RELAY
        pending  = (is_wr ? bus.req_write_valid : bus.req_read_valid) & mask;
        unique case (state)
            IDLE: if (found) begin
                id_n    = pick_id;
                is_wr_n = !bus.req_read_valid[pick_id];
                addr_n  = is_wr_n ? bus.req_write_address[pick_id] : bus.req_read_address[pick_id];
                wdata_n = bus.req_write_data[pick_id];
                state_n = is_wr_n ? WRITE_WAIT : READ_WAIT;
            end
            READ_WAIT:  state_n = bus.mem_read_ready ? RELAY : READ_WAIT;
            WRITE_WAIT: state_n = bus.mem_write_ready ? RELAY : WRITE_WAIT;
            RELAY: if (pending == '0) begin
                state_n  = IDLE;
                rr_ptr_n = (id_q == REQ_ID_BITS'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
            end
        endcase
    end

`ifdef LSU_ARB_READ_MERGE_EN
    logic [NUM_REQ-1:0] merge_q, same_addr;

    always_comb begin
        same_addr = '0;
        for (int i = 0; i < NUM_REQ; i++)
            same_addr[i] = bus.req_read_valid[i] &&
                           bus.req_read_address[i] == bus.req_read_address[pick_id];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) merge_q <= '0;
        else if (state == IDLE && found)
            merge_q <= bus.req_read_valid[pick_id] ? same_addr : NUM_REQ'(1) << pick_id;
    end

    assign mask = merge_q;
`else
    assign mask = NUM_REQ'(1) << id_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rdata <= '0;
        else if (state == READ_WAIT && bus.mem_read_ready)
            for (int i = 0; i < NUM_REQ; i++)
                if (mask[i]) rdata[i] <= bus.mem_read_data;
    end

    assign busy                  = state != IDLE;
    assign grant_id              = id_q;
    assign bus.mem_read_valid    = state == READ_WAIT;
    assign bus.mem_write_valid   = state == WRITE_WAIT;
    assign bus.mem_read_address  = addr_q;
    assign bus.mem_write_address = addr_q;
    assign bus.mem_write_data    = wdata_q;
    assign bus.req_read_ready    = (state == RELAY && !is_wr) ? mask : '0;
    assign bus.req_write_ready   = (state == RELAY && is_wr) ? mask : '0;
    assign bus.req_read_data     = rdata;
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb_lsu_mem_arbiter: directed scenarios plus randomized traffic against a memory/scoreboard model
module tb_lsu_mem_arbiter;
    localparam int NR = 2;
    localparam int AB = 8;
    localparam int DB = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       busy;
    logic [0:0] grant_id;

    lsu_mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_REQ(NR)) bus();

    lsu_mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_REQ(NR)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int grants = 0;
    int fix_lat = 1;
    int lat = 1;
    int rcnt = 0;
    int wcnt = 0;
    bit auto_drop = 1'b1;
    logic prev_rv = 1'b0;
    logic prev_wv = 1'b0;

    logic [DB-1:0] mem [256];
    logic [DB-1:0] ref_mem [256];
    logic [NR-1:0] rd_v = '0;
    logic [NR-1:0] wr_v = '0;
    logic [AB-1:0] rd_a [NR];
    logic [AB-1:0] wr_a [NR];
    logic [DB-1:0] wd [NR];
    int            rstart [NR];

    bit            log_wr [$];
    logic [AB-1:0] log_addr [$];
    int            log_gid [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        bus.req_read_valid  = rd_v;
        bus.req_write_valid = wr_v;
        for (int i = 0; i < NR; i++) begin
            bus.req_read_address[i]  = rd_a[i];
            bus.req_write_address[i] = wr_a[i];
            bus.req_write_data[i]    = wd[i];
        end
    endtask

    task automatic req_rd(input int i, input logic [AB-1:0] a);
        rd_v[i] = 1'b1;
        rd_a[i] = a;
        rstart[i] = grants;
        drive();
    endtask

    task automatic req_wr(input int i, input logic [AB-1:0] a, input logic [DB-1:0] d);
        wr_v[i] = 1'b1;
        wr_a[i] = a;
        wd[i] = d;
        drive();
    endtask

    task automatic clr_log();
        log_wr.delete();
        log_addr.delete();
        log_gid.delete();
    endtask

    // One negedge: memory controller model, then every requester reacts to its readies
    task automatic step();
        @(negedge clk);
        bus.mem_read_ready  = 1'b0;
        bus.mem_write_ready = 1'b0;
        if (!reset) begin
            rcnt = 0;
            wcnt = 0;
            prev_rv = 1'b0;
            prev_wv = 1'b0;
        end else begin
            if (bus.mem_read_valid) begin
                if (!prev_rv) begin
                    grants++;
                    log_wr.push_back(1'b0);
                    log_addr.push_back(bus.mem_read_address);
                    log_gid.push_back(int'(grant_id));
                    lat = fix_lat > 0 ? fix_lat : $urandom_range(1, 3);
                    rcnt = 0;
                end
                rcnt++;
                if (rcnt >= lat) begin
                    bus.mem_read_ready = 1'b1;
                    bus.mem_read_data  = mem[bus.mem_read_address];
                end
            end
            if (bus.mem_write_valid) begin
                if (!prev_wv) begin
                    grants++;
                    log_wr.push_back(1'b1);
                    log_addr.push_back(bus.mem_write_address);
                    log_gid.push_back(int'(grant_id));
                    lat = fix_lat > 0 ? fix_lat : $urandom_range(1, 3);
                    wcnt = 0;
                end
                wcnt++;
                if (wcnt >= lat) begin
                    bus.mem_write_ready = 1'b1;
                    mem[bus.mem_write_address] = bus.mem_write_data;
                end
            end
            prev_rv = bus.mem_read_valid;
            prev_wv = bus.mem_write_valid;
            for (int i = 0; i < NR; i++) begin
                if (rd_v[i] && bus.req_read_ready[i]) begin
                    chk("read_data", 32'(bus.req_read_data[i]), 32'(ref_mem[rd_a[i]]));
                    chk("fairness", 32'(grants - rstart[i] <= NR), 32'd1);
                    if (auto_drop) rd_v[i] = 1'b0;
                end
                if (wr_v[i] && bus.req_write_ready[i]) begin
                    ref_mem[wr_a[i]] = wd[i];
                    if (auto_drop) wr_v[i] = 1'b0;
                end
            end
        end
        drive();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((rd_v | wr_v) != '0 && n < 200) begin
            step();
            n++;
        end
        step();
        chk(tag, 32'((rd_v | wr_v) == '0 && !busy), 32'd1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < NR; i++) begin
            rd_a[i] = '0;
            wr_a[i] = '0;
            wd[i] = '0;
            rstart[i] = 0;
        end
        bus.mem_read_ready = 1'b0;
        bus.mem_write_ready = 1'b0;
        bus.mem_read_data = '0;
        drive();

        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_valid", 32'({bus.mem_read_valid, bus.mem_write_valid}), 32'd0);
        chk("rst_ready", 32'({bus.req_read_ready, bus.req_write_ready}), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        reset = 1'b1;

        // Single read, memory answers on the second cycle, requester holds valid an extra cycle
        mem[8'h10] = 8'h5A;
        ref_mem[8'h10] = 8'h5A;
        fix_lat = 2;
        auto_drop = 1'b0;
        clr_log();
        req_rd(1, 8'h10);
        n = 0;
        while (!bus.req_read_ready[1] && n < 20) begin
            step();
            n++;
        end
        chk("t1_ready", 32'(bus.req_read_ready[1]), 32'd1);
        chk("t1_data", 32'(bus.req_read_data[1]), 32'h5A);
        chk("t1_lane0", 32'({bus.req_read_ready[0], bus.req_write_ready[0], bus.req_read_data[0]}), 32'd0);
        chk("t1_addr", 32'(log_addr[0]), 32'h10);
        step();
        chk("t1_hold", 32'(bus.req_read_ready[1]), 32'd1);
        auto_drop = 1'b1;
        step();
        step();
        chk("t1_release", 32'({bus.req_read_ready, busy}), 32'd0);

        // Simultaneous writes, pointer at 0
        fix_lat = 1;
        clr_log();
        req_wr(0, 8'h20, 8'h11);
        req_wr(1, 8'h21, 8'h22);
        wait_done("t2_done");
        chk("t2_count", 32'(log_addr.size()), 32'd2);
        chk("t2_first", 32'({log_wr[0], log_addr[0]}), 32'h120);
        chk("t2_second", 32'({log_wr[1], log_addr[1]}), 32'h121);
        chk("t2_gids", 32'({log_gid[0][0], log_gid[1][0]}), 32'b01);
        chk("t2_mem", 32'({mem[8'h20], mem[8'h21]}), 32'h1122);

        // Lone requester 1, then both: pointer wrapped back to 0
        clr_log();
        req_rd(1, 8'h50);
        wait_done("t3a_done");
        req_rd(0, 8'h51);
        req_rd(1, 8'h52);
        wait_done("t3b_done");
        chk("t3_gids", 32'({log_gid[0][0], log_gid[1][0], log_gid[2][0]}), 32'b101);

        // Read and write valid together: read goes first
        clr_log();
        req_rd(0, 8'h60);
        req_wr(0, 8'h61, 8'h77);
        wait_done("t4_done");
        chk("t4_order", 32'({log_wr[0], log_wr[1]}), 32'b01);
        chk("t4_addrs", 32'({log_addr[0], log_addr[1]}), 32'h6061);

        // Reset during READ_WAIT: outputs clear immediately, pointer back to 0
        fix_lat = 10;
        clr_log();
        req_rd(1, 8'h70);
        n = 0;
        while (!bus.mem_read_valid && n < 10) begin
            step();
            n++;
        end
        chk("t5_inflight", 32'(bus.mem_read_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t5_async", 32'({bus.mem_read_valid, bus.mem_write_valid, busy, grant_id,
                             bus.req_read_ready, bus.req_write_ready}), 32'd0);
        chk("t5_addr", 32'(bus.mem_read_address), 32'd0);
        rd_v = '0;
        drive();
        step();
        step();
        reset = 1'b1;
        fix_lat = 1;
        clr_log();
        req_rd(1, 8'h71);
        req_rd(0, 8'h72);
        wait_done("t5_done");
        chk("t5_regrant", 32'(log_gid[0]), 32'd0);

`ifdef LSU_ARB_READ_MERGE_EN
        // Same-address reads share one memory transaction
        mem[8'h30] = 8'h3C;
        ref_mem[8'h30] = 8'h3C;
        clr_log();
        auto_drop = 1'b0;
        req_rd(0, 8'h30);
        req_rd(1, 8'h30);
        n = 0;
        while (bus.req_read_ready == '0 && n < 20) begin
            step();
            n++;
        end
        chk("t6_both_ready", 32'(bus.req_read_ready), 32'b11);
        chk("t6_data", 32'({bus.req_read_data[0], bus.req_read_data[1]}), 32'h3C3C);
        chk("t6_one_tx", 32'(log_addr.size()), 32'd1);
        auto_drop = 1'b1;
        wait_done("t6_done");
`endif

        // Randomized traffic on a small address window to force contention and reuse
        fix_lat = 0;
        for (int k = 0; k < 400; k++) begin
            step();
            for (int i = 0; i < NR; i++) begin
                if (!rd_v[i] && !wr_v[i] && !bus.req_read_ready[i] && !bus.req_write_ready[i]
                    && $urandom_range(0, 2) == 0) begin
                    n = $urandom_range(0, 2);
                    if (n != 1) req_rd(i, AB'(8'h40 + $urandom_range(0, 7)));
                    if (n != 0) req_wr(i, AB'(8'h40 + $urandom_range(0, 7)), DB'($urandom));
                end
            end
        end
        wait_done("drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
